// File: rtl/im_config_loader.sv
// Loads ID (12-bit) and immediate (33-bit) instruction memories from a DTL slave port.
// Latency: an IM write appears 1 cycle after its consuming beat; the first read beat
//          is valid 1 cycle after command accept.
// Backpressure: commands accepted only in IDLE; write beats are always accepted in WRITE;
//          read data is held until iReadAccept.
//
// Ports:
//   iClk, iReset (async, active low)
//   DTL command : iCommandValid/oCommandAccept, iCommandReadWrite (1=write), iAddress, iBlockSize
//   DTL write   : iWriteValid/oWriteAccept, iWriteData, iWriteLast
//   DTL read    : oReadValid/iReadAccept, oReadData, oReadLast
//   IM side     : oIM_WriteEnable (one-hot pulse), oIM_WriteAddress, oIM_WriteData, oIM_WriteData_IMM
//   Status      : oConfigDone, oError (sticky)
module im_config_loader #(
    parameter int NUM_ID                = 10,
    parameter int NUM_IMM               = 4,
    parameter int I_WIDTH               = 12,
    parameter int I_IMM_WIDTH           = 33,
    parameter int IM_MEM_ADDR_WIDTH     = 8,
    parameter int INTERFACE_WIDTH       = 32,
    parameter int INTERFACE_ADDR_WIDTH  = 32,
    parameter int INTERFACE_BLOCK_WIDTH = 5
) (
    input  logic                             iClk,
    input  logic                             iReset,
    // command channel
    input  logic                             iCommandValid,
    output logic                             oCommandAccept,
    input  logic                             iCommandReadWrite,
    input  logic [INTERFACE_ADDR_WIDTH-1:0]  iAddress,
    input  logic [INTERFACE_BLOCK_WIDTH-1:0] iBlockSize,
    // write data channel
    input  logic                             iWriteValid,
    output logic                             oWriteAccept,
    input  logic [INTERFACE_WIDTH-1:0]       iWriteData,
    input  logic                             iWriteLast,
    // read data channel
    output logic                             oReadValid,
    input  logic                             iReadAccept,
    output logic [INTERFACE_WIDTH-1:0]       oReadData,
    output logic                             oReadLast,
    // instruction memory write side
    output logic [NUM_ID+NUM_IMM-1:0]        oIM_WriteEnable,
    output logic [IM_MEM_ADDR_WIDTH-1:0]     oIM_WriteAddress,
    output logic [I_WIDTH-1:0]               oIM_WriteData,
    output logic [I_IMM_WIDTH-1:0]           oIM_WriteData_IMM,
    // status
    output logic                             oConfigDone,
    output logic                             oError
);

    localparam int NUM_IM = NUM_ID + NUM_IMM;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_WRITE = 2'd1;
    localparam logic [1:0] ST_READ  = 2'd2;

    // Select ranges: [0, NUM_ID) ID memories, [NUM_ID, NUM_IM) IMM memories, 31 control.
    localparam logic [4:0] SEL_ID_END  = 5'(NUM_ID);
    localparam logic [4:0] SEL_IMM_END = 5'(NUM_IM);
    localparam logic [4:0] SEL_CTRL    = 5'd31;

    localparam logic [IM_MEM_ADDR_WIDTH-1:0]     WORD_ONE = 1;
    localparam logic [INTERFACE_BLOCK_WIDTH-1:0] BLK_ONE  = 1;
    localparam logic [NUM_IM-1:0]                WE_ONE   = 1;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [1:0]                       state;
    logic [4:0]                       sel;
    logic [IM_MEM_ADDR_WIDTH-1:0]     word;
    logic [INTERFACE_BLOCK_WIDTH-1:0] blk;
    logic [INTERFACE_BLOCK_WIDTH-1:0] rd_cnt;
    logic                             imm_odd;   // next IMM beat supplies bit 32
    logic [INTERFACE_WIDTH-1:0]       imm_lo;    // low 32 bits held from the even beat

    // ------------------------------------------------------------------
    // Command address decode
    // ------------------------------------------------------------------
    logic [4:0]                   addr_sel;
    logic [IM_MEM_ADDR_WIDTH-1:0] addr_word;
    logic                         unused_addr_bits;

    assign addr_word = iAddress[IM_MEM_ADDR_WIDTH+1:2];
    assign addr_sel  = iAddress[IM_MEM_ADDR_WIDTH+6:IM_MEM_ADDR_WIDTH+2];
    // Byte-lane bits and bits above the select field carry no meaning here.
    assign unused_addr_bits = ^{iAddress[INTERFACE_ADDR_WIDTH-1:IM_MEM_ADDR_WIDTH+7], iAddress[1:0]};

    assign oCommandAccept = (state == ST_IDLE);
    assign oWriteAccept   = (state == ST_WRITE);

    // ------------------------------------------------------------------
    // Write-beat classification
    // ------------------------------------------------------------------
    logic                       beat;
    logic                       sel_id;
    logic                       sel_imm;
    logic                       sel_ctrl;
    logic                       wr_id;
    logic                       imm_even;
    logic                       wr_imm;
    logic                       err_set;
    logic                       err_clr;
    logic [INTERFACE_WIDTH-1:0] status;

    always_comb begin
        beat     = 1'b0;
        sel_id   = 1'b0;
        sel_imm  = 1'b0;
        sel_ctrl = 1'b0;
        wr_id    = 1'b0;
        imm_even = 1'b0;
        wr_imm   = 1'b0;
        err_set  = 1'b0;
        err_clr  = 1'b0;

        beat     = (state == ST_WRITE) && iWriteValid;
        sel_id   = (sel < SEL_ID_END);
        sel_imm  = (sel >= SEL_ID_END) && (sel < SEL_IMM_END);
        sel_ctrl = (sel == SEL_CTRL);

        // Once configuration is marked done, IM beats are dropped and flagged.
        wr_id    = beat && sel_id  && !oConfigDone;
        imm_even = beat && sel_imm && !oConfigDone && !imm_odd;
        wr_imm   = beat && sel_imm && !oConfigDone &&  imm_odd;

        err_set  = beat && (((sel_id || sel_imm) && oConfigDone)
                            || (!sel_id && !sel_imm && !sel_ctrl)
                            || (imm_even && iWriteLast));   // IMM burst cut on a half word
        err_clr  = beat && sel_ctrl && iWriteData[1];
    end

    assign status = {{(INTERFACE_WIDTH-2){1'b0}}, oError, oConfigDone};

    // ------------------------------------------------------------------
    // Main sequential logic
    // ------------------------------------------------------------------
    always_ff @(posedge iClk or negedge iReset) begin
        if (!iReset) begin
            state             <= ST_IDLE;
            sel               <= '0;
            word              <= '0;
            blk               <= '0;
            rd_cnt            <= '0;
            imm_odd           <= 1'b0;
            imm_lo            <= '0;
            oIM_WriteEnable   <= '0;
            oIM_WriteAddress  <= '0;
            oIM_WriteData     <= '0;
            oIM_WriteData_IMM <= '0;
            oReadValid        <= 1'b0;
            oReadLast         <= 1'b0;
            oReadData         <= '0;
            oConfigDone       <= 1'b0;
            oError            <= 1'b0;
        end else begin
            // Enable is a single-cycle pulse.
            oIM_WriteEnable <= '0;

            case (state)
                ST_IDLE: begin
                    if (iCommandValid) begin
                        sel     <= addr_sel;
                        word    <= addr_word;
                        blk     <= iBlockSize;
                        imm_odd <= 1'b0;
                        if (iCommandReadWrite) begin
                            state <= ST_WRITE;
                        end else begin
                            // First read beat presented straight away.
                            state      <= ST_READ;
                            rd_cnt     <= '0;
                            oReadValid <= 1'b1;
                            oReadData  <= status;
                            oReadLast  <= (iBlockSize == '0);
                        end
                    end
                end

                ST_WRITE: begin
                    if (wr_id) begin
                        oIM_WriteEnable  <= WE_ONE << sel;
                        oIM_WriteAddress <= word;
                        oIM_WriteData    <= iWriteData[I_WIDTH-1:0];
                        word             <= word + WORD_ONE;   // wraps silently
                    end
                    if (imm_even) begin
                        imm_lo  <= iWriteData;
                        imm_odd <= 1'b1;
                    end
                    if (wr_imm) begin
                        oIM_WriteEnable   <= WE_ONE << sel;
                        oIM_WriteAddress  <= word;
                        oIM_WriteData_IMM <= I_IMM_WIDTH'({iWriteData[0], imm_lo});
                        word              <= word + WORD_ONE;
                        imm_odd           <= 1'b0;
                    end
                    if (beat && sel_ctrl) begin
                        oConfigDone <= iWriteData[0];
                    end
                    // Burst length is governed by iWriteLast alone.
                    if (beat && iWriteLast) begin
                        state   <= ST_IDLE;
                        imm_odd <= 1'b0;
                    end
                end

                ST_READ: begin
                    if (iReadAccept) begin
                        if (oReadLast) begin
                            state      <= ST_IDLE;
                            oReadValid <= 1'b0;
                            oReadLast  <= 1'b0;
                        end else begin
                            rd_cnt    <= rd_cnt + BLK_ONE;
                            oReadData <= status;
                            oReadLast <= ((rd_cnt + BLK_ONE) == blk);
                        end
                    end
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase

            // A clear from the control select wins over any set in the same beat.
            if (err_clr) begin
                oError <= 1'b0;
            end else if (err_set) begin
                oError <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_im_config_loader.sv
module tb_im_config_loader;

    localparam int NIM = 14;

    logic        iClk = 1'b0;
    logic        iReset;
    logic        iCommandValid;
    logic        oCommandAccept;
    logic        iCommandReadWrite;
    logic [31:0] iAddress;
    logic [4:0]  iBlockSize;
    logic        iWriteValid;
    logic        oWriteAccept;
    logic [31:0] iWriteData;
    logic        iWriteLast;
    logic        oReadValid;
    logic        iReadAccept;
    logic [31:0] oReadData;
    logic        oReadLast;
    logic [NIM-1:0] oIM_WriteEnable;
    logic [7:0]  oIM_WriteAddress;
    logic [11:0] oIM_WriteData;
    logic [32:0] oIM_WriteData_IMM;
    logic        oConfigDone;
    logic        oError;

    im_config_loader dut (
        .iClk              (iClk),
        .iReset            (iReset),
        .iCommandValid     (iCommandValid),
        .oCommandAccept    (oCommandAccept),
        .iCommandReadWrite (iCommandReadWrite),
        .iAddress          (iAddress),
        .iBlockSize        (iBlockSize),
        .iWriteValid       (iWriteValid),
        .oWriteAccept      (oWriteAccept),
        .iWriteData        (iWriteData),
        .iWriteLast        (iWriteLast),
        .oReadValid        (oReadValid),
        .iReadAccept       (iReadAccept),
        .oReadData         (oReadData),
        .oReadLast         (oReadLast),
        .oIM_WriteEnable   (oIM_WriteEnable),
        .oIM_WriteAddress  (oIM_WriteAddress),
        .oIM_WriteData     (oIM_WriteData),
        .oIM_WriteData_IMM (oIM_WriteData_IMM),
        .oConfigDone       (oConfigDone),
        .oError            (oError)
    );

    always #5 iClk = ~iClk;

    int cyc = 0;
    always @(posedge iClk) cyc <= cyc + 1;

    int checks = 0;
    int passes = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    endtask

    // Scoreboard of expected IM writes
    typedef struct {
        logic [NIM-1:0] we;
        logic [7:0]     addr;
        logic [11:0]    dat;
        logic [32:0]    imm;
        bit             is_imm;
        int             cyc;
    } wr_t;

    wr_t sb[$];

    // Called at the drive point of the beat that should cause the write.
    task automatic push_id(input logic [4:0] s, input logic [7:0] a, input logic [11:0] d);
        wr_t e;
        e.we = NIM'(1) << s; e.addr = a; e.dat = d; e.imm = '0; e.is_imm = 1'b0; e.cyc = cyc + 1;
        sb.push_back(e);
    endtask

    task automatic push_imm(input logic [4:0] s, input logic [7:0] a, input logic [32:0] d);
        wr_t e;
        e.we = NIM'(1) << s; e.addr = a; e.dat = '0; e.imm = d; e.is_imm = 1'b1; e.cyc = cyc + 1;
        sb.push_back(e);
    endtask

    always @(negedge iClk) begin
        if (iReset === 1'b1 && oIM_WriteEnable !== '0) begin
            if (sb.size() == 0) begin
                chk("unexpected_im_write", 64'(oIM_WriteEnable), 64'd0);
            end else begin
                wr_t e;
                e = sb.pop_front();
                chk("im_enable", 64'(oIM_WriteEnable), 64'(e.we));
                chk("im_addr", 64'(oIM_WriteAddress), 64'(e.addr));
                if (e.is_imm) chk("im_data_imm", 64'(oIM_WriteData_IMM), 64'(e.imm));
                else          chk("im_data", 64'(oIM_WriteData), 64'(e.dat));
                chk("im_latency", 64'(cyc), 64'(e.cyc));
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin @(posedge iClk); #1; end
    endtask

    task automatic cmd(input bit rw, input logic [4:0] s, input logic [7:0] w, input logic [4:0] bs);
        int n = 0;
        iCommandValid = 1'b1; iCommandReadWrite = rw; iAddress = {17'b0, s, w, 2'b11}; iBlockSize = bs;
        while (!oCommandAccept && n < 50) begin @(posedge iClk); #1; n++; end
        chk("cmd_accept", 64'(oCommandAccept), 64'd1);
        @(posedge iClk); #1;
        iCommandValid = 1'b0;
    endtask

    task automatic wbeat(input logic [31:0] d, input bit last);
        iWriteValid = 1'b1; iWriteData = d; iWriteLast = last;
        chk("write_accept", 64'(oWriteAccept), 64'd1);
        @(posedge iClk); #1;
        iWriteValid = 1'b0; iWriteLast = 1'b0;
    endtask

    task automatic st(input string nm, input bit err, input bit done);
        chk({nm, "_error"}, 64'(oError), 64'(err));
        chk({nm, "_done"},  64'(oConfigDone), 64'(done));
    endtask

    task automatic rd(input logic [4:0] bs, input int dly, input logic [31:0] expd);
        cmd(1'b0, 5'd31, 8'd0, bs);
        for (int b = 0; b <= int'(bs); b++) begin
            for (int k = 0; k < dly; k++) begin
                chk("rd_valid_held", 64'(oReadValid), 64'd1);
                chk("rd_data_stable", 64'(oReadData), 64'(expd));
                chk("rd_last_held", 64'(oReadLast), 64'(b == int'(bs)));
                @(posedge iClk); #1;
            end
            chk("rd_valid", 64'(oReadValid), 64'd1);
            chk("rd_data", 64'(oReadData), 64'(expd));
            chk("rd_last", 64'(oReadLast), 64'(b == int'(bs)));
            iReadAccept = 1'b1;
            @(posedge iClk); #1;
            iReadAccept = 1'b0;
        end
        chk("rd_end_valid", 64'(oReadValid), 64'd0);
        chk("rd_end_accept", 64'(oCommandAccept), 64'd1);
    endtask

    task automatic chk_all_zero(input string nm);
        chk({nm, "_we"},    64'(oIM_WriteEnable), 64'd0);
        chk({nm, "_addr"},  64'(oIM_WriteAddress), 64'd0);
        chk({nm, "_data"},  64'(oIM_WriteData), 64'd0);
        chk({nm, "_imm"},   64'(oIM_WriteData_IMM), 64'd0);
        chk({nm, "_rvld"},  64'(oReadValid), 64'd0);
        chk({nm, "_rlast"}, 64'(oReadLast), 64'd0);
        chk({nm, "_rdata"}, 64'(oReadData), 64'd0);
        chk({nm, "_done"},  64'(oConfigDone), 64'd0);
        chk({nm, "_err"},   64'(oError), 64'd0);
    endtask

    typedef struct {
        logic [4:0]  s;
        logic [7:0]  w;
        logic [31:0] d;
        bit          wr;
        logic [11:0] ed;
        bit          eerr;
        bit          edone;
    } vec_t;

    vec_t tbl[6];

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        // single-beat writes: {select, word, data, write expected, IM data, error, done}
        tbl[0] = '{5'd0,  8'h10, 32'h0000_0ABC, 1'b1, 12'hABC, 1'b0, 1'b0};
        tbl[1] = '{5'd9,  8'hFF, 32'hFFFF_F123, 1'b1, 12'h123, 1'b0, 1'b0};
        tbl[2] = '{5'd20, 8'h00, 32'h0000_0005, 1'b0, 12'h000, 1'b1, 1'b0};
        tbl[3] = '{5'd31, 8'h00, 32'h0000_0002, 1'b0, 12'h000, 1'b0, 1'b0};
        tbl[4] = '{5'd14, 8'h33, 32'h0000_0777, 1'b0, 12'h000, 1'b1, 1'b0};
        tbl[5] = '{5'd31, 8'h00, 32'h0000_0002, 1'b0, 12'h000, 1'b0, 1'b0};

        iReset = 1'b1; iCommandValid = 0; iCommandReadWrite = 0; iAddress = 0; iBlockSize = 0;
        iWriteValid = 0; iWriteData = 0; iWriteLast = 0; iReadAccept = 0;
        #2 iReset = 1'b0;
        #1 chk_all_zero("reset");
        repeat (2) @(posedge iClk);
        #1 iReset = 1'b1;
        chk("reset_release_accept", 64'(oCommandAccept), 64'd1);
        idle(1);

        for (int i = 0; i < 6; i++) begin
            cmd(1'b1, tbl[i].s, tbl[i].w, 5'd0);
            if (tbl[i].wr) push_id(tbl[i].s, tbl[i].w, tbl[i].ed);
            wbeat(tbl[i].d, 1'b1);
            idle(1);
            st($sformatf("tbl%0d", i), tbl[i].eerr, tbl[i].edone);
            chk($sformatf("tbl%0d_drain", i), 64'(sb.size()), 64'd0);
        end

        // select 2, word 5, three back-to-back beats
        cmd(1'b1, 5'd2, 8'd5, 5'd2);
        push_id(5'd2, 8'd5, 12'hABC); wbeat(32'h0000_0ABC, 1'b0);
        push_id(5'd2, 8'd6, 12'h123); wbeat(32'h0000_0123, 1'b0);
        push_id(5'd2, 8'd7, 12'hFFF); wbeat(32'h0000_0FFF, 1'b1);
        idle(2);
        chk("id_burst_drain", 64'(sb.size()), 64'd0);
        st("id_burst", 1'b0, 1'b0);

        // IMM0 at word 0xFF, second pair wraps to 0x00
        cmd(1'b1, 5'd10, 8'hFF, 5'd3);
        wbeat(32'h89AB_CDEF, 1'b0);
        push_imm(5'd10, 8'hFF, 33'h1_89AB_CDEF); wbeat(32'h0000_0001, 1'b0);
        wbeat(32'h0000_0011, 1'b0);
        push_imm(5'd10, 8'h00, 33'h0_0000_0011); wbeat(32'h0000_0000, 1'b1);
        idle(2);
        chk("imm_wrap_drain", 64'(sb.size()), 64'd0);
        st("imm_wrap", 1'b0, 1'b0);

        // IMM burst ending on an even beat, then clear via control
        cmd(1'b1, 5'd11, 8'h20, 5'd2);
        wbeat(32'h1357_2468, 1'b0);
        push_imm(5'd11, 8'h20, 33'h1_1357_2468); wbeat(32'h0000_0001, 1'b0);
        wbeat(32'hDEAD_BEEF, 1'b1);
        idle(2);
        chk("imm_odd_drain", 64'(sb.size()), 64'd0);
        st("imm_odd", 1'b1, 1'b0);
        cmd(1'b1, 5'd31, 8'd0, 5'd0); wbeat(32'h2, 1'b1); idle(1);
        st("err_clear", 1'b0, 1'b0);

        // config done blocks IM writes
        cmd(1'b1, 5'd31, 8'd0, 5'd0); wbeat(32'h1, 1'b1); idle(1);
        st("cfg_done", 1'b0, 1'b1);
        cmd(1'b1, 5'd0, 8'd3, 5'd0); wbeat(32'h55, 1'b1); idle(2);
        chk("blocked_drain", 64'(sb.size()), 64'd0);
        st("blocked", 1'b1, 1'b1);
        rd(5'd0, 0, 32'h0000_0003);

        // two-beat read with accept held low
        rd(5'd1, 3, 32'h0000_0003);

        cmd(1'b1, 5'd31, 8'd0, 5'd0); wbeat(32'h2, 1'b1); idle(1);
        st("cfg_clear", 1'b0, 1'b0);

        // reset in the middle of a 4-beat burst
        cmd(1'b1, 5'd1, 8'h40, 5'd3);
        push_id(5'd1, 8'h40, 12'h111); wbeat(32'h111, 1'b0);
        idle(1);
        iWriteValid = 1'b1; iWriteData = 32'h222;
        #2 iReset = 1'b0;
        #1 chk_all_zero("mid_reset");
        chk("mid_reset_accept", 64'(oCommandAccept), 64'd1);
        iWriteValid = 1'b0;
        repeat (2) @(posedge iClk);
        #1 iReset = 1'b1;
        chk("post_reset_accept", 64'(oCommandAccept), 64'd1);
        idle(3);
        chk("post_reset_drain", 64'(sb.size()), 64'd0);
        cmd(1'b1, 5'd0, 8'd7, 5'd0);
        push_id(5'd0, 8'd7, 12'h007); wbeat(32'h7, 1'b1);
        idle(2);
        chk("final_drain", 64'(sb.size()), 64'd0);
        st("final", 1'b0, 1'b0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/im_config_loader.md
IM_CONFIG_LOADER -- requirements
Module: im_config_loader

Interface
REQ-001 SHALL have parameter NUM_ID, default 10, number of ID instruction memories (12-bit words).
REQ-002 SHALL have parameter NUM_IMM, default 4, number of immediate instruction memories (33-bit words), indices NUM_ID..NUM_ID+NUM_IMM-1.
REQ-003 SHALL have parameters I_WIDTH 12, I_IMM_WIDTH 33, IM_MEM_ADDR_WIDTH 8, INTERFACE_WIDTH 32, INTERFACE_ADDR_WIDTH 32, INTERFACE_BLOCK_WIDTH 5.
REQ-004 SHALL have ports: iClk in 1 clock; iReset in 1 asynchronous active-low reset.
REQ-005 SHALL have DTL slave ports: iCommandValid in 1; oCommandAccept out 1; iCommandReadWrite in 1 (1=write); iAddress in INTERFACE_ADDR_WIDTH byte address; iBlockSize in INTERFACE_BLOCK_WIDTH beats-1.
REQ-006 SHALL have: iWriteValid in 1; oWriteAccept out 1; iWriteData in INTERFACE_WIDTH; iWriteLast in 1; oReadValid out 1; iReadAccept in 1; oReadData out INTERFACE_WIDTH; oReadLast out 1.
REQ-007 SHALL have: oIM_WriteEnable out NUM_ID+NUM_IMM one-hot; oIM_WriteAddress out IM_MEM_ADDR_WIDTH; oIM_WriteData out I_WIDTH; oIM_WriteData_IMM out I_IMM_WIDTH; oConfigDone out 1; oError out 1 sticky.

Function
REQ-008 SHALL decode command address: word = iAddress[IM_MEM_ADDR_WIDTH+1:2]; select = iAddress[IM_MEM_ADDR_WIDTH+6:IM_MEM_ADDR_WIDTH+2]; bits [1:0] ignored.
REQ-009 SHALL implement FSM states IDLE, WRITE, READ; oCommandAccept = 1 only in IDLE.
REQ-010 SHALL, in IDLE with iCommandValid, latch select, word, iBlockSize and go to WRITE if iCommandReadWrite=1, else READ.
REQ-011 SHALL drive oWriteAccept = 1 throughout WRITE; a beat is consumed when iWriteValid=1 in WRITE.
REQ-012 SHALL, for select < NUM_ID, write iWriteData[I_WIDTH-1:0] to memory select at current word, one write per beat.
REQ-013 SHALL, for IMM selects, take two beats per word: even beat = bits [31:0] (held), odd beat bit 0 = bit 32; write issued on odd beat only.
REQ-014 SHALL register IM writes: oIM_WriteEnable/address/data valid exactly 1 cycle after the consuming beat, enable a single-cycle pulse.
REQ-015 SHALL increment word after each IM write, wrapping 2^IM_MEM_ADDR_WIDTH-1 -> 0 without error.
REQ-016 SHALL, for select = 31, treat each beat as control write: oConfigDone <= iWriteData[0]; bit 1 = 1 clears oError.
REQ-017 SHALL discard beats for any other select and set oError.
REQ-018 SHALL, while oConfigDone=1, discard IM-targeted beats (no enable pulse) and set oError.
REQ-019 SHALL return WRITE -> IDLE on the beat with iWriteLast=1; beat count vs iBlockSize is not checked.
REQ-020 SHALL set oError and issue no write when an IMM burst ends on an even beat.
REQ-021 SHALL, in READ, return iBlockSize+1 beats of {30'b0, oError, oConfigDone}; oReadValid held until iReadAccept; oReadLast on final beat; READ -> IDLE on final accepted beat.
REQ-022 SHALL hold oReadData stable while oReadValid=1 and iReadAccept=0.
REQ-023 SHALL give a clear of oError via select 31 precedence over a same-cycle set.

Reset
REQ-024 SHALL, on iReset=0, immediately go to IDLE and drive oIM_WriteEnable 0, oIM_WriteAddress 0, oIM_WriteData 0, oIM_WriteData_IMM 0, oReadValid 0, oReadLast 0, oReadData 0, oConfigDone 0, oError 0, with any held IMM low half cleared.
REQ-025 SHALL abandon a mid-burst transfer on reset with no further IM write; oCommandAccept = 1 in the first cycle after release.

Verification
REQ-026 SHALL cover: write select 2, word 5, 3 beats 0xABC,0x123,0xFFF -> enable bit 2 pulses at addresses 5,6,7 with those data, 1-cycle latency.
REQ-027 SHALL cover: write select 10 (IMM0), word 0xFF, beats 0x89ABCDEF,0x1 -> single write at 0xFF, data 0x1_89ABCDEF; a further pair writes address 0x00.
REQ-028 SHALL cover: select 31 beat 0x1 then IM write to select 0 -> oConfigDone=1, no enable pulse, oError=1; read 1 beat -> 0x00000003.
REQ-029 SHALL cover: IMM burst of 3 beats -> one write, then oError=1; select 31 beat 0x2 -> oError=0.
REQ-030 SHALL cover: read 2 beats with iReadAccept low 3 cycles -> oReadValid held, data stable, oReadLast only on beat 2.
REQ-031 SHALL cover: iReset low mid-burst after beat 1 of 4 -> all outputs 0 asynchronously, no further writes, next command accepted.
